// File: rtl/skullfet_tester_pkg.sv
// Shared types and defaults for the SKULLFET inverter tester.
package skullfet_tester_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    // Wide enough for settle_eff (max 15) plus the deepest synchronizer.
    localparam int unsigned SETTLE_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // A zero settle request still waits one cycle.
    function automatic logic [3:0] settle_eff(input logic [3:0] settle);
        return (settle == 4'd0) ? 4'd1 : settle;
    endfunction

endpackage

// File: rtl/skullfet_tester_if.sv
// Control, status and inverter-under-test signals of the tester, grouped for the environment side.
interface skullfet_tester_if
    import skullfet_tester_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic [3:0]       settle;
    logic             dut_a;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] toggles;
    logic [CNT_W-1:0] err_cnt;

    // master: controller plus the inverter under test; slave: the tester itself.
    modport master (
        output start, abort, count, settle, dut_y,
        input  dut_a, busy, done, pass, toggles, err_cnt
    );

    modport slave (
        input  start, abort, count, settle, dut_y,
        output dut_a, busy, done, pass, toggles, err_cnt
    );

endinterface

// File: rtl/skullfet_sync.sv
// Multi-flop synchronizer bringing the asynchronous inverter output into the clock domain.
module skullfet_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/skullfet_tester.sv
// Toggles the inverter-under-test input, waits for it to settle, and counts mismatches on its output.
module skullfet_tester
    import skullfet_tester_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [3:0]       settle_i,
    output logic             dut_a_o,
    input  logic             dut_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] toggles_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    toggles_q, toggles_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [SETTLE_W-1:0] reload_q, reload_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                dut_a_q, dut_a_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                y_sync;
    logic                mismatch;
    logic [SETTLE_W-1:0] reload_new;
    logic [CNT_W-1:0]    toggles_inc;
    logic [CNT_W-1:0]    err_inc;

    skullfet_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_ni),
        .d_i  (dut_y_i),
        .q_o  (y_sync)
    );

    // Settle countdown runs reload..0, i.e. settle_eff+SYNC_STAGES cycles in SETTLE.
    assign reload_new  = SETTLE_W'(settle_eff(settle_i)) + SETTLE_W'(SYNC_STAGES - 1);
    assign mismatch    = (y_sync != ~dut_a_q);
    assign toggles_inc = toggles_q + 1'b1;
    assign err_inc     = (err_q == '1) ? err_q : err_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d      = state_q;
        count_d      = count_q;
        toggles_d    = toggles_q;
        err_d        = err_q;
        reload_d     = reload_q;
        settle_cnt_d = settle_cnt_q;
        dut_a_d      = dut_a_q;
        done_d       = done_q;
        pass_d       = pass_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    count_d   = count_i;
                    reload_d  = reload_new;
                    toggles_d = '0;
                    err_d     = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    if (count_i != '0) begin
                        dut_a_d      = ~dut_a_q;
                        settle_cnt_d = reload_new;
                        state_d      = ST_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    toggles_d = toggles_inc;
                    if (mismatch) begin
                        err_d = err_inc;
                    end
                    if (toggles_inc == count_q) begin
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        dut_a_d      = ~dut_a_q;
                        settle_cnt_d = reload_q;
                        state_d      = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            toggles_q    <= '0;
            err_q        <= '0;
            reload_q     <= '0;
            settle_cnt_q <= '0;
            dut_a_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            toggles_q    <= toggles_d;
            err_q        <= err_d;
            reload_q     <= reload_d;
            settle_cnt_q <= settle_cnt_d;
            dut_a_q      <= dut_a_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_a_o   = dut_a_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign toggles_o = toggles_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_skullfet_tester.sv
// Directed and randomized runs of skullfet_tester against an arithmetic model of each test run.
module tb_skullfet_tester;
    import skullfet_tester_pkg::*;

    localparam int CNT_W = 16;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Inverter-under-test model: 0 = lagging inverter, 1 = Y stuck 0, 2 = Y stuck 1.
    int          y_mode = 0;
    int          y_lag  = 1;
    logic [15:0] hist   = '1;
    bit          a_model = 1'b0;

    always #5 clk = ~clk;

    skullfet_tester_if #(.CNT_W(CNT_W)) tif ();

    skullfet_tester #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .start_i  (tif.start),
        .abort_i  (tif.abort),
        .count_i  (tif.count),
        .settle_i (tif.settle),
        .dut_a_o  (tif.dut_a),
        .dut_y_i  (tif.dut_y),
        .busy_o   (tif.busy),
        .done_o   (tif.done),
        .pass_o   (tif.pass),
        .toggles_o(tif.toggles),
        .err_cnt_o(tif.err_cnt)
    );

    // Y as sampled at rising edge m equals ~A(m - y_lag); lag 1 is an ideal zero-delay inverter.
    always @(negedge clk) begin
        hist = {hist[14:0], ~tif.dut_a};
        case (y_mode)
            1:       tif.dut_y = 1'b0;
            2:       tif.dut_y = 1'b1;
            default: tif.dut_y = hist[y_lag-1];
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check k samples Y at edge k*P-SYNC (start edge = 0); A toggles at edges 0, P, 2P, ...
    function automatic void model_run(input int cnt, input int st, input int mode, input int lag,
                                      input bit a0, output int err, output int done_n);
        int p;
        int j;
        int tg;
        bit a_chk;
        bit a_j;
        bit y;
        p   = ((st == 0) ? 1 : st) + SYNC + 1;
        err = 0;
        for (int k = 1; k <= cnt; k++) begin
            a_chk = a0 ^ k[0];
            j     = k * p - SYNC - lag;
            if (j < 0) tg = 0;
            else begin
                tg = j / p + 1;
                if (tg > cnt) tg = cnt;
            end
            a_j = a0 ^ tg[0];
            y   = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~a_j;
            if (y != ~a_chk) err++;
        end
        done_n = cnt * p;
    endfunction

    task automatic do_run(input string tag, input int cnt, input int st, input int mode,
                          input int lag, input int poke_at, output int done_n);
        int exp_err;
        int exp_n;
        int n;
        bit a0;
        bit prev;
        bit aq[$];
        tif.count  = CNT_W'(cnt);
        tif.settle = 4'(st);
        y_mode     = mode;
        y_lag      = lag;
        repeat (10) @(negedge clk);
        a0 = a_model;
        model_run(cnt, st, mode, lag, a0, exp_err, exp_n);
        tif.start = 1'b1;
        @(negedge clk);
        tif.start  = 1'b0;
        tif.count  = CNT_W'($urandom_range(0, 20));
        tif.settle = 4'($urandom_range(0, 15));
        check({tag, "_busy_first"}, tif.busy, (cnt != 0));
        n    = 0;
        prev = a0;
        while (!tif.done && n < exp_n + 50) begin
            if (tif.dut_a !== prev) begin
                aq.push_back(tif.dut_a);
                prev = tif.dut_a;
            end
            tif.start = (n == poke_at);
            @(negedge clk);
            n++;
        end
        tif.start = 1'b0;
        check({tag, "_done_cycle"}, n, exp_n);
        check({tag, "_done"}, tif.done, 1);
        check({tag, "_toggles"}, tif.toggles, cnt);
        check({tag, "_err"}, tif.err_cnt, exp_err);
        check({tag, "_pass"}, tif.pass, (exp_err == 0));
        check({tag, "_busy_end"}, tif.busy, 0);
        check({tag, "_a_final"}, tif.dut_a, a0 ^ cnt[0]);
        check({tag, "_a_edges"}, aq.size(), cnt);
        for (int i = 0; i < aq.size() && i < cnt; i++)
            check({tag, "_a_seq"}, 32'(aq[i]), 32'(a0 ^ !i[0]));
        a_model = a0 ^ cnt[0];
        done_n  = n;
    endtask

    task automatic do_abort(input string tag, input int cnt, input int st, input int abort_at,
                            input int exp_tog, input int exp_flips);
        bit a0;
        tif.count  = CNT_W'(cnt);
        tif.settle = 4'(st);
        y_mode     = 0;
        y_lag      = 1;
        repeat (10) @(negedge clk);
        a0 = a_model;
        tif.start = 1'b1;
        @(negedge clk);
        tif.start = 1'b0;
        repeat (abort_at) @(negedge clk);
        tif.abort = 1'b1;
        @(negedge clk);
        tif.abort = 1'b0;
        check({tag, "_busy"}, tif.busy, 0);
        check({tag, "_done"}, tif.done, 0);
        check({tag, "_pass"}, tif.pass, 0);
        check({tag, "_toggles"}, tif.toggles, exp_tog);
        check({tag, "_a"}, tif.dut_a, a0 ^ exp_flips[0]);
        repeat (5) @(negedge clk);
        check({tag, "_toggles_hold"}, tif.toggles, exp_tog);
        check({tag, "_a_hold"}, tif.dut_a, a0 ^ exp_flips[0]);
        check({tag, "_err_hold"}, tif.err_cnt, 0);
        a_model = a0 ^ exp_flips[0];
    endtask

    initial begin
        int n;
        int cnt;
        int st;
        int mode;
        int lag;

        rst_n      = 1'b0;
        tif.start  = 1'b0;
        tif.abort  = 1'b0;
        tif.count  = '0;
        tif.settle = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", tif.busy, 0);
        check("rst_done", tif.done, 0);
        check("rst_pass", tif.pass, 0);
        check("rst_toggles", tif.toggles, 0);
        check("rst_err", tif.err_cnt, 0);
        check("rst_a", tif.dut_a, 0);
        rst_n = 1'b1;

        // Ideal inverter, count 4, settle 1.
        do_run("ideal_c4", 4, 1, 0, 1, -1, n);
        check("ideal_c4_at16", n, 16);
        check("ideal_c4_err0", tif.err_cnt, 0);
        check("ideal_c4_pass1", tif.pass, 1);

        // Y stuck at 0, count 4, settle 3.
        do_run("stuck0_c4", 4, 3, 1, 1, -1, n);
        check("stuck0_c4_at24", n, 24);
        check("stuck0_c4_err2", tif.err_cnt, 2);
        check("stuck0_c4_pass0", tif.pass, 0);

        // Six-cycle lagging inverter, count 3, settle 1.
        do_run("lag6_c3", 3, 1, 0, 6, -1, n);
        check("lag6_c3_err3", tif.err_cnt, 3);
        check("lag6_c3_pass0", tif.pass, 0);

        // Zero-length run completes on the start edge.
        do_run("zero", 0, 5, 0, 1, -1, n);
        check("zero_at0", n, 0);

        // abort_i in DONE leaves the result alone.
        tif.abort = 1'b1;
        repeat (3) @(negedge clk);
        tif.abort = 1'b0;
        check("abort_done_done", tif.done, 1);
        check("abort_done_pass", tif.pass, 1);

        // Abort during CHECK wins over the increment; abort after the 2nd CHECK.
        do_abort("abort_chk", 10, 1, 3, 0, 1);
        do_abort("abort_2nd", 10, 1, 8, 2, 3);
        do_run("restart", 3, 1, 0, 1, -1, n);

        // A start pulse mid-run must not restart it.
        do_run("busy_start", 3, 2, 0, 1, 5, n);
        check("busy_start_at15", n, 15);

        // Reset in the middle of SETTLE.
        tif.count  = CNT_W'(8);
        tif.settle = 4'd2;
        repeat (10) @(negedge clk);
        tif.start = 1'b1;
        @(negedge clk);
        tif.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", tif.busy, 0);
        check("midrst_done", tif.done, 0);
        check("midrst_pass", tif.pass, 0);
        check("midrst_toggles", tif.toggles, 0);
        check("midrst_err", tif.err_cnt, 0);
        check("midrst_a", tif.dut_a, 0);
        a_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_run("after_rst", 1, 1, 0, 1, -1, n);

        // Randomized runs over count, settle and inverter behaviour.
        for (int r = 0; r < 12; r++) begin
            cnt  = $urandom_range(0, 9);
            st   = $urandom_range(0, 15);
            mode = $urandom_range(0, 2);
            lag  = $urandom_range(1, 8);
            do_run("rand", cnt, st, mode, lag, -1, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
